uart_tx_rr_arbiter: RTL and testbench
=====================================

Name: uart_tx_rr_arbiter

Overview:
Shares one AXI-stream UART transmitter among N AXI-stream requesters using packet-locked round-robin arbitration.
- A grant is held from the first beat of a packet until its tlast beat is accepted, or until a burst limit is reached.
- After release, the arbiter waits for the UART to finish shifting and then inserts a programmable idle gap before re-arbitrating.
- Sits between the channel sources (command/log/debug streams) and the UART TX core. Its m_axis_* connects to the TX s_axis_*, and the TX busy drives busy_in.

Parameters:
N_CH, 4, number of requesting channels (2..16)
DATA_WIDTH, 8, beat width; must equal the UART TX DATA_WIDTH
ID_WIDTH, 2, width of channel index; must satisfy 2**ID_WIDTH >= N_CH
GAP_CYCLES, 2, idle clk cycles between TX-idle and the next arbitration (0 = none)
MAX_BURST, 0, beats per grant before forced release (0 = unlimited, lock until tlast)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  N_CH*DATA_WIDTH  channel data, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  N_CH  per-channel valid
s_axis_tlast  in  N_CH  per-channel end-of-packet
s_axis_tready  out  N_CH  per-channel ready
m_axis_tdata  out  DATA_WIDTH  data to UART TX
m_axis_tvalid  out  1  valid to UART TX
m_axis_tready  in  1  ready from UART TX
busy_in  in  1  UART TX busy (frame in progress)
grant_valid  out  1  high in LOCK state
grant_id  out  ID_WIDTH  currently/last granted channel
burst_cut  out  1  one-cycle pulse when a grant is released by MAX_BURST instead of tlast

Behaviour:
Reset (rst=1 at a clk edge):
- state=IDLE; all s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; grant_valid=0; grant_id=0; burst_cut=0.
- Round-robin pointer last=N_CH-1, so channel 0 has first priority.
- Beat and gap counters=0.
- Reset mid-packet abandons the grant immediately. No partial beat is presented afterwards.

State IDLE:
- Outputs are quiet.
- If any s_axis_tvalid is high, select the first valid channel searching last+1, last+2, ... modulo N_CH.
- Register it into grant_id and last; beat counter=0; go to LOCK next cycle. Arbitration latency is 1 cycle.

State LOCK (grant g):
- m_axis_tvalid=s_axis_tvalid[g] and m_axis_tdata=channel g data, both combinational pass-through.
- s_axis_tready[g]=m_axis_tready; all other tready=0. grant_valid=1.
- A beat is accepted when m_axis_tvalid & m_axis_tready; the beat counter increments.
- On an accepted beat with tlast[g]=1, go to DRAIN.
- Otherwise, if MAX_BURST!=0 and the beat counter reaches MAX_BURST, pulse burst_cut for 1 cycle and go to DRAIN.
- If tlast and the limit occur on the same beat, treat it as tlast (burst_cut=0).
- Deasserted tvalid[g] mid-packet keeps the lock. No timeout.

State DRAIN:
- All tready=0; m_axis_tvalid=0.
- The first DRAIN cycle ignores busy_in, because the TX raises busy one cycle after acceptance.
- From the second cycle on, when busy_in=0: go to GAP if GAP_CYCLES>0 (gap counter=0), else go to IDLE.

State GAP:
- Outputs quiet. The gap counter increments each cycle.
- When it reaches GAP_CYCLES-1, go to IDLE.
- New tvalid during GAP is ignored until IDLE.

General rules:
- grant_id holds its value outside LOCK.
- No combinational path from s_axis_tvalid to s_axis_tready.
- Width rules: the beat counter is clog2(MAX_BURST+1) bits (minimum 1) and must never wrap inside a grant. The gap counter is clog2(GAP_CYCLES+1) bits.

Test Plan:
- Reset then single request: ch2 sends a 3-beat packet A1,A2,A3 (tlast on A3) -> 1 idle cycle, then grant_id=2, grant_valid=1; m_axis_tdata sequence A1,A2,A3; DRAIN until busy_in falls; 2 GAP cycles; IDLE.
- Fairness: all 4 channels hold continuous 1-beat packets -> grant order 0,1,2,3,0,1 with no channel served twice before the others.
- Lock integrity: ch1 packet of 4 beats with tvalid dropped for 5 cycles after beat 2, ch0 valid throughout -> ch0 tready stays 0 until ch1's tlast is accepted; then ch0 is granted next.
- Burst limit: MAX_BURST=2, ch3 sends a 5-beat packet -> grant released after 2 beats with burst_cut pulse; other channels are served; ch3 resumes with beat 3 on its next grant.
- Backpressure: m_axis_tready low for 10 cycles mid-packet -> m_axis_tdata stable, no beat lost or duplicated, granted tready mirrors m_axis_tready.
- Reset mid-LOCK: assert rst during beat 2 -> next cycle state IDLE, all tready=0, m_axis_tvalid=0; after release, ch0 wins first.

Source files
------------

// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter
// ------------------
// Shares one AXI-stream UART transmitter among N_CH AXI-stream requesters.
// Arbitration is round-robin. A grant stays with one channel for a whole
// packet, or until MAX_BURST beats have gone through when that limit is set.
// After a grant is released, the arbiter waits for the UART to stop shifting.
// It then idles for GAP_CYCLES clocks before it arbitrates again.
//
// Ports:
//   clk            system clock, everything on the rising edge
//   rst            synchronous active-high reset
//   s_axis_tdata   per-channel beat data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid  per-channel valid
//   s_axis_tlast   per-channel end-of-packet
//   s_axis_tready  per-channel ready (only the granted channel ever sees ready)
//   m_axis_tdata   beat data towards the UART TX
//   m_axis_tvalid  valid towards the UART TX
//   m_axis_tready  ready from the UART TX
//   busy_in        UART TX frame-in-progress flag
//   grant_valid    high while a channel holds the grant
//   grant_id       currently / most recently granted channel
//   burst_cut      one-cycle pulse when a grant ends on the burst limit

module uart_tx_rr_arbiter #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_BURST  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]              s_axis_tvalid,
  input  logic [N_CH-1:0]              s_axis_tlast,
  output logic [N_CH-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         busy_in,
  output logic                         grant_valid,
  output logic [ID_WIDTH-1:0]          grant_id,
  output logic                         burst_cut
);

  localparam int BEAT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    (MAX_BURST > 0) ? BEAT_W'(MAX_BURST - 1) : '0;
  localparam logic [GAP_W-1:0]  GAP_LAST  =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last_id;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                drain_first;

  logic [ID_WIDTH-1:0] pick;
  logic                beat_acc;
  logic                limit_hit;

  // Round-robin search starting just after the last served channel.
  // Channel last+1 has the highest priority and channel last the lowest.
  always_comb begin
    int cand;
    logic found;
    pick  = last_id;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = int'(last_id) + i;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (!found && s_axis_tvalid[cand[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_WIDTH-1:0];
      end
    end
  end

  // The granted channel is wired straight through to the UART while locked.
  // Its tready depends only on the UART's ready, never on the channel's own
  // valid, so no valid-to-ready path exists.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    if (state == ST_LOCK) begin
      s_axis_tready[grant_id] = m_axis_tready;
      m_axis_tvalid           = s_axis_tvalid[grant_id];
      m_axis_tdata            = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign beat_acc  = m_axis_tvalid & m_axis_tready;
  // The beat being accepted is the last one the burst limit allows.
  assign limit_hit = (MAX_BURST > 0) && (beat_cnt == LAST_BEAT);

  // Main sequencer: IDLE -> LOCK -> DRAIN -> (GAP) -> IDLE.
  // The first DRAIN cycle ignores busy_in, because the UART raises busy one
  // clock after it accepts a beat. When the burst limit is off, the beat
  // counter never moves, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      last_id     <= ID_WIDTH'(N_CH - 1);
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      drain_first <= 1'b0;
      grant_valid <= 1'b0;
      burst_cut   <= 1'b0;
    end else begin
      burst_cut <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            grant_id    <= pick;
            last_id     <= pick;
            beat_cnt    <= '0;
            grant_valid <= 1'b1;
            state       <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (beat_acc) begin
            if (MAX_BURST > 0) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (s_axis_tlast[grant_id]) begin
              grant_valid <= 1'b0;
              drain_first <= 1'b1;
              state       <= ST_DRAIN;
            end else if (limit_hit) begin
              grant_valid <= 1'b0;
              drain_first <= 1'b1;
              burst_cut   <= 1'b1;
              state       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_first) begin
            drain_first <= 1'b0;
          end else if (!busy_in) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              state   <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// tb_uart_tx_rr_arbiter
// ---------------------
// Runs two arbiter instances side by side.
//   Instance 0: GAP_CYCLES=2, MAX_BURST=0 (lock until tlast).
//   Instance 1: GAP_CYCLES=0, MAX_BURST=2.
// Each instance has its own packet sources, UART sink and reference model.
// The model tracks grants in terms of owner channel and the earliest cycle at
// which arbitration may happen again. A short scripted opening gives
// hand-derived cycle-exact expectations. Random traffic, backpressure, busy
// and resets follow it.

module tb_uart_tx_rr_arbiter;

  localparam int N          = 4;
  localparam int W          = 8;
  localparam int IW         = 2;
  localparam int RAND_START = 40;
  localparam int END_CYC    = 4000;
  localparam int RST_MID    = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [N*W-1:0] s_tdata  [2];
  logic [N-1:0]   s_tvalid [2];
  logic [N-1:0]   s_tlast  [2];
  logic [N-1:0]   s_tready [2];
  logic [W-1:0]   m_tdata  [2];
  logic           m_tvalid [2];
  logic           m_tready [2];
  logic           busy     [2];
  logic           gvalid   [2];
  logic [IW-1:0]  gid      [2];
  logic           bcut     [2];

  for (genvar k = 0; k < 2; k++) begin : g_cfg
    uart_tx_rr_arbiter #(
      .N_CH       (N),
      .DATA_WIDTH (W),
      .ID_WIDTH   (IW),
      .GAP_CYCLES ((k == 0) ? 2 : 0),
      .MAX_BURST  ((k == 0) ? 0 : 2)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata[k]),
      .s_axis_tvalid (s_tvalid[k]),
      .s_axis_tlast  (s_tlast[k]),
      .s_axis_tready (s_tready[k]),
      .m_axis_tdata  (m_tdata[k]),
      .m_axis_tvalid (m_tvalid[k]),
      .m_axis_tready (m_tready[k]),
      .busy_in       (busy[k]),
      .grant_valid   (gvalid[k]),
      .grant_id      (gid[k]),
      .burst_cut     (bcut[k])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Source state: a queue of pending {tlast, data} beats per instance/channel.
  logic [W:0]   srcq [2*N][$];
  logic [N-1:0] von        [2];
  logic [N-1:0] acc_s      [2];
  logic         m_acc      [2];
  int           busy_left  [2];
  int           stall_left [2];
  int           pkt_seq    [2];

  // Reference model state.
  int owner       [2];
  int ptr         [2];
  int gid_m       [2];
  int beats       [2];
  int arb_from    [2];
  int drain_start [2];
  bit waiting     [2];
  bit cut_m       [2];
  bit model_ok    [2];

  function automatic int mb_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic cmp(input string what, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s inst%0d cyc%0d: got %0h expected %0h",
               what, k, cyc, act, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming clock edge.
  task automatic checkOutput(input int k);
    logic [N-1:0] e_rdy;
    logic         e_mv;
    logic         e_gv;
    logic [W-1:0] e_md;
    logic         acc;
    bit           cut_next;
    int           o;
    int           pick;
    o = owner[k];
    acc_s[k] = s_tvalid[k] & s_tready[k];
    m_acc[k] = m_tvalid[k] & m_tready[k];
    if (model_ok[k]) begin
      e_rdy = '0;
      e_mv  = 1'b0;
      e_gv  = 1'b0;
      e_md  = '0;
      if (o >= 0) begin
        e_gv     = 1'b1;
        e_mv     = s_tvalid[k][o];
        e_md     = s_tdata[k][o*W +: W];
        e_rdy[o] = m_tready[k];
      end
      cmp("s_tready",    k, 32'(s_tready[k]), 32'(e_rdy));
      cmp("m_tvalid",    k, 32'(m_tvalid[k]), 32'(e_mv));
      cmp("m_tdata",     k, 32'(m_tdata[k]),  32'(e_md));
      cmp("grant_valid", k, 32'(gvalid[k]),   32'(e_gv));
      cmp("grant_id",    k, 32'(gid[k]),      32'(gid_m[k]));
      cmp("burst_cut",   k, 32'(bcut[k]),     32'(cut_m[k]));
    end
    acc = 1'b0;
    if (o >= 0) begin
      acc = s_tvalid[k][o] & m_tready[k];
    end
    cut_next = 1'b0;
    if (rst) begin
      owner[k]    = -1;
      ptr[k]      = N - 1;
      gid_m[k]    = 0;
      waiting[k]  = 1'b0;
      arb_from[k] = cyc + 1;
      model_ok[k] = 1'b1;
    end else if (!model_ok[k]) begin
      owner[k] = -1;
    end else if (o >= 0) begin
      if (acc) begin
        beats[k]++;
        if (s_tlast[k][o] || (mb_of(k) != 0 && beats[k] == mb_of(k))) begin
          cut_next       = !s_tlast[k][o];
          owner[k]       = -1;
          waiting[k]     = 1'b1;
          drain_start[k] = cyc + 1;
        end
      end
    end else if (waiting[k]) begin
      if (cyc >= drain_start[k] + 1 && !busy[k]) begin
        waiting[k]  = 1'b0;
        arb_from[k] = cyc + 1 + gap_of(k);
      end
    end else if (cyc >= arb_from[k]) begin
      pick = -1;
      for (int i = 1; i <= N; i++) begin
        if (pick < 0 && s_tvalid[k][(ptr[k] + i) % N]) begin
          pick = (ptr[k] + i) % N;
        end
      end
      if (pick >= 0) begin
        owner[k] = pick;
        ptr[k]   = pick;
        gid_m[k] = pick;
        beats[k] = 0;
      end
    end
    cut_m[k] = cut_next;
  endtask

  // Drive the sources and the UART-side sink for the next cycle.
  // A presented beat stays valid until it is handshaken.
  task automatic applyStimulus(input int k);
    bit           directed;
    int           idx;
    int           len;
    logic [W:0]   head;
    logic [W-1:0] d;
    directed = (cyc < RAND_START);
    if (cyc == 3) begin
      srcq[k*N+2].push_back({1'b0, 8'hA1});
      srcq[k*N+2].push_back({1'b0, 8'hA2});
      srcq[k*N+2].push_back({1'b1, 8'hA3});
    end
    if (cyc == 8) begin
      srcq[k*N+0].push_back({1'b1, 8'hB0});
    end
    if (cyc == 30) begin
      srcq[k*N+1].push_back({1'b0, 8'hC1});
      srcq[k*N+1].push_back({1'b0, 8'hC2});
      srcq[k*N+1].push_back({1'b0, 8'hC3});
      srcq[k*N+1].push_back({1'b1, 8'hC4});
      srcq[k*N+0].push_back({1'b1, 8'hD0});
    end
    for (int ch = 0; ch < N; ch++) begin
      idx = k*N + ch;
      if (acc_s[k][ch] && srcq[idx].size() > 0) begin
        void'(srcq[idx].pop_front());
        von[k][ch] = 1'b0;
        if (srcq[idx].size() > 0 && (directed || $urandom_range(0, 9) < 7)) begin
          von[k][ch] = 1'b1;
        end
      end
      if (!directed && srcq[idx].size() == 0 && $urandom_range(0, 5) == 0) begin
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          pkt_seq[k]++;
          d = W'((ch << 6) | (pkt_seq[k] & 63));
          srcq[idx].push_back({(b == len - 1), d});
        end
      end
      if (!von[k][ch] && srcq[idx].size() > 0 &&
          (directed || $urandom_range(0, 9) < 5)) begin
        von[k][ch] = 1'b1;
      end
      head = (srcq[idx].size() > 0) ? srcq[idx][0] : '0;
      s_tvalid[k][ch]        = von[k][ch];
      s_tlast[k][ch]         = von[k][ch] & head[W];
      s_tdata[k][ch*W +: W]  = head[W-1:0];
    end
    if (directed) begin
      m_tready[k] = 1'b1;
    end else if (stall_left[k] > 0) begin
      m_tready[k] = 1'b0;
      stall_left[k]--;
    end else if ($urandom_range(0, 59) == 0) begin
      m_tready[k]   = 1'b0;
      stall_left[k] = 9;
    end else begin
      m_tready[k] = ($urandom_range(0, 3) != 0);
    end
    if (m_acc[k]) begin
      busy_left[k] = directed ? 3 : int'($urandom_range(0, 6));
    end
    busy[k] = (busy_left[k] > 0);
    if (busy_left[k] > 0) begin
      busy_left[k]--;
    end
  endtask

  // Hand-derived expectations for the scripted opening. They pin reset
  // values, arbitration latency, pass-through order, gap length, burst
  // cut and the reset-mid-packet recovery.
  task automatic checkLiterals();
    case (cyc)
      2: begin
        cmp("lit_rst_tready", 0, 32'(s_tready[0]), 32'h0);
        cmp("lit_rst_gid",    0, 32'(gid[0]),      32'h0);
        cmp("lit_rst_mdata",  0, 32'(m_tdata[0]),  32'h0);
        cmp("lit_rst_cut",    1, 32'(bcut[1]),     32'h0);
      end
      3: cmp("lit_idle_gvalid", 0, 32'(gvalid[0]), 32'h0);
      4: begin
        cmp("lit_grant_valid", 0, 32'(gvalid[0]),  32'h1);
        cmp("lit_grant_id",    0, 32'(gid[0]),     32'h2);
        cmp("lit_beat_a1",     0, 32'(m_tdata[0]), 32'hA1);
      end
      5: cmp("lit_beat_a2", 0, 32'(m_tdata[0]), 32'hA2);
      6: begin
        cmp("lit_beat_a3",    0, 32'(m_tdata[0]), 32'hA3);
        cmp("lit_cut_pulse",  1, 32'(bcut[1]),    32'h1);
        cmp("lit_cut_gvalid", 1, 32'(gvalid[1]),  32'h0);
      end
      7: begin
        cmp("lit_drain_gvalid", 0, 32'(gvalid[0]), 32'h0);
        cmp("lit_drain_gid",    0, 32'(gid[0]),    32'h2);
        cmp("lit_cut_cleared",  1, 32'(bcut[1]),   32'h0);
      end
      11: begin
        cmp("lit_after_cut_gid", 1, 32'(gid[1]),    32'h0);
        cmp("lit_gap_gvalid",    0, 32'(gvalid[0]), 32'h0);
      end
      13: cmp("lit_gap_end_gvalid", 0, 32'(gvalid[0]), 32'h0);
      14: begin
        cmp("lit_next_grant_id", 0, 32'(gid[0]),     32'h0);
        cmp("lit_next_gvalid",   0, 32'(gvalid[0]),  32'h1);
        cmp("lit_beat_b0",       0, 32'(m_tdata[0]), 32'hB0);
      end
      17: begin
        cmp("lit_resume_gid", 1, 32'(gid[1]),     32'h2);
        cmp("lit_resume_a3",  1, 32'(m_tdata[1]), 32'hA3);
      end
      33: begin
        cmp("lit_midrst_tready", 0, 32'(s_tready[0]), 32'h0);
        cmp("lit_midrst_mvalid", 0, 32'(m_tvalid[0]), 32'h0);
        cmp("lit_midrst_gvalid", 0, 32'(gvalid[0]),   32'h0);
        cmp("lit_midrst_gid",    0, 32'(gid[0]),      32'h0);
      end
      34: begin
        cmp("lit_postrst_gid",    0, 32'(gid[0]),    32'h0);
        cmp("lit_postrst_gvalid", 0, 32'(gvalid[0]), 32'h1);
      end
      default: ;
    endcase
  endtask

  // Single control process: check on the falling edge, drive just after
  // the rising edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      s_tdata[k]     = '0;
      s_tvalid[k]    = '0;
      s_tlast[k]     = '0;
      m_tready[k]    = 1'b0;
      busy[k]        = 1'b0;
      von[k]         = '0;
      acc_s[k]       = '0;
      m_acc[k]       = 1'b0;
      busy_left[k]   = 0;
      stall_left[k]  = 0;
      pkt_seq[k]     = 0;
      owner[k]       = -1;
      ptr[k]         = N - 1;
      gid_m[k]       = 0;
      beats[k]       = 0;
      arb_from[k]    = 0;
      drain_start[k] = 0;
      waiting[k]     = 1'b0;
      cut_m[k]       = 1'b0;
      model_ok[k]    = 1'b0;
    end
    rst = 1'b1;
    while (cyc < END_CYC) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkOutput(k);
      end
      checkLiterals();
      @(posedge clk);
      cyc++;
      #1;
      rst = (cyc < 3) || (cyc == RST_MID) ||
            (cyc >= RAND_START && $urandom_range(0, 799) == 0);
      for (int k = 0; k < 2; k++) begin
        applyStimulus(k);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
